md_ctrl: RTL

//  Iterative multiply/divide sequencer that owns the HI/LO register pair of the

---
 rtl/md_ctrl_pkg.sv | 37 +++
 rtl/md_ctrl_if.sv | 29 ++
 rtl/md_negate.sv | 13 +
 rtl/md_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared op codes, FSM encoding and small decode helpers for the HI/LO
// multiply/divide sequencer.
package md_ctrl_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // Iterative ops occupy codes 0..3; bit 1 separates divide from multiply.
  function automatic logic op_is_iter(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// EX-stage to multiply/divide unit bus: operation request plus HI/LO and busy.
interface md_ctrl_if
  import md_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  // Handshake: start is a one-cycle valid; the unit is ready when busy is 0.
  // A start seen while busy is dropped, so decode must stall MD users on busy.
  logic             start;
  logic [2:0]       mdctr;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  md_state_e        state_dbg;

  modport master (
    output start, mdctr, A, B,
    input  busy, hi, lo, state_dbg
  );

  modport slave (
    input  start, mdctr, A, B,
    output busy, hi, lo, state_dbg
  );

endinterface

// File: rtl/md_negate.sv
// Conditional two's-complement of an N-bit bus; passes the input through when
// en is low.
module md_negate #(
  parameter int N = 64
) (
  input  logic         en,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  assign dout = en ? (~din + N'(1)) : din;

endmodule

// File: rtl/md_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO: shift-add multiply and
// restoring divide on magnitudes, with a one-cycle sign fix before write-back.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  md_ctrl_if.slave    bus
);

  md_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_div_q, is_div_d;
  logic                   s_a_q, s_a_d;
  logic                   s_b_q, s_b_d;
  logic                   div0_q, div0_d;
  // MUL: {partial product, multiplier}. DIV: low half is dividend/quotient.
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  // MUL: |A| multiplicand. DIV: |B| divisor.
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  logic                   in_fix;
  logic                   sgn_op;
  logic                   wide_en, narrow_en;
  logic [2*WIDTH-1:0]     wide_in, wide_out;
  logic [WIDTH-1:0]       narrow_in, narrow_out;
  logic [WIDTH:0]         mul_sum;
  logic [WIDTH:0]         div_shift;
  logic [WIDTH:0]         div_diff;

  assign in_fix = (state_q == ST_FIX);
  assign sgn_op = op_is_signed(bus.mdctr);

  // The two negators are shared: operand magnitudes at issue, sign fix in FIX.
  assign wide_in   = in_fix ? (is_div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q)
                            : {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
  assign wide_en   = in_fix ? (s_a_q ^ s_b_q) : (sgn_op & bus.A[WIDTH-1]);
  assign narrow_in = in_fix ? rem_q : bus.B;
  assign narrow_en = in_fix ? s_a_q : (sgn_op & bus.B[WIDTH-1]);

  md_negate #(.N(2*WIDTH)) u_neg_wide (
    .en   (wide_en),
    .din  (wide_in),
    .dout (wide_out)
  );

  md_negate #(.N(WIDTH)) u_neg_narrow (
    .en   (narrow_en),
    .din  (narrow_in),
    .dout (narrow_out)
  );

  // Trial subtract is one bit wider than the remainder so it cannot overflow.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    s_a_d    = s_a_q;
    s_b_d    = s_b_q;
    div0_d   = div0_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (op_is_iter(bus.mdctr)) begin
            cnt_d    = '0;
            is_div_d = op_is_div(bus.mdctr);
            s_a_d    = sgn_op & bus.A[WIDTH-1];
            s_b_d    = sgn_op & bus.B[WIDTH-1];
            div0_d   = (bus.B == '0);
            rem_d    = '0;
            if (op_is_div(bus.mdctr)) begin
              acc_d   = {{WIDTH{1'b0}}, wide_out[WIDTH-1:0]};
              opnd_d  = narrow_out;
              state_d = ST_DIV;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, narrow_out};
              opnd_d  = wide_out[WIDTH-1:0];
              state_d = ST_MUL;
            end
          end else if (bus.mdctr == MD_MTHI) begin
            hi_d = bus.A;
          end else if (bus.mdctr == MD_MTLO) begin
            lo_d = bus.A;
          end
        end
      end

      ST_MUL: begin
        acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                         : {1'b0, acc_q[2*WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FIX;
      end

      ST_DIV: begin
        if (!div_diff[WIDTH]) begin
          rem_d = div_diff[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FIX;
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!is_div_q) begin
          {hi_d, lo_d} = wide_out;
        end else if (!div0_q) begin
          lo_d = wide_out[WIDTH-1:0];
          hi_d = narrow_out;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      s_a_q    <= 1'b0;
      s_b_q    <= 1'b0;
      div0_q   <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      s_a_q    <= s_a_d;
      s_b_q    <= s_b_d;
      div0_q   <= div0_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.state_dbg = state_q;

endmodule
